data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 256, sets the number of 32-bit words stored.
REQ-002 Parameter WAIT_CYCLES, default 2, range 0..15, sets the wait states inserted before each response.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port read_En, input, 1 bit: read request from the MEM stage.
REQ-006 Port write_En, input, 1 bit: write request from the MEM stage.
REQ-007 Port DataAddress, input, 32 bits: byte address of the request.
REQ-008 Port WriteData, input, 32 bits: write data.
REQ-009 Port read_data, output, 32 bits: read result.
REQ-010 Port mem_ready, output, 1 bit: one-cycle response strobe.
REQ-011 Port mem_err, output, 1 bit: error flag, qualified by mem_ready.
REQ-012 Port mem_busy, output, 1 bit: high whenever the FSM is not in IDLE; the pipeline uses it as a stall.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-014 In IDLE, if read_En or write_En is high, the block SHALL latch the operation, DataAddress and WriteData.
REQ-015 On that acceptance, the FSM SHALL go to WAIT if WAIT_CYCLES>0, otherwise directly to RESP.
REQ-016 WAIT SHALL load a down-counter with WAIT_CYCLES-1 on entry and move to RESP when the counter is 0; the counter width is 4 bits.
REQ-017 With a request first seen in IDLE in cycle 0, mem_ready SHALL be high in cycle WAIT_CYCLES+1, for exactly one cycle.
REQ-018 The block SHALL return to IDLE in the cycle after RESP, for a minimum request-to-request spacing of WAIT_CYCLES+2 cycles.
REQ-019 The initiator holds its request until it sees mem_ready; inputs SHALL be sampled only on acceptance in IDLE, so input changes in WAIT or RESP are ignored.
REQ-020 Successful read: read_data SHALL equal mem[DataAddress[31:2]] during the mem_ready cycle and be 0 in every other cycle.
REQ-021 Successful write: the word SHALL be written at the clock edge that ends the RESP cycle; read_data stays 0 for writes.
REQ-022 If DataAddress[1:0]!=0 (misaligned), mem_err SHALL be asserted with mem_ready, with no write and read_data=0.
REQ-023 If the word index is >= DEPTH (out of range), mem_err SHALL be asserted with mem_ready, with no write and read_data=0.
REQ-024 If read_En and write_En are both high at acceptance, mem_err SHALL be asserted with mem_ready, with no write and read_data=0.
REQ-025 Error responses SHALL use the same WAIT_CYCLES latency as successful ones.
REQ-026 The word index is DataAddress[31:2]; bits above log2(DEPTH) SHALL count toward the out-of-range check, never wrap.
REQ-027 A read of a word written by the immediately preceding request SHALL return the new value.

Reset
REQ-028 On a clock edge with reset=1, state SHALL become IDLE, the counter 0, and read_data, mem_ready, mem_err and mem_busy 0 in the following cycle.
REQ-029 Reset asserted in WAIT or RESP SHALL abort the transaction; a pending write SHALL be discarded and no mem_ready issued for it.
REQ-030 Memory contents SHALL NOT be cleared by reset; their initial contents are undefined.
REQ-031 Reset SHALL take priority over a simultaneous request; the request is ignored that cycle.

Structure
REQ-032 A shared package SHALL hold the state encoding (IDLE=0, WAIT=1, RESP=2, 2 bits) and the default DEPTH and WAIT_CYCLES constants.
REQ-033 Storage SHALL be one sub-module, dmem_word_array: a single-port word array with write-enable and combinational read, DEPTH words.
REQ-034 The FSM, counter, latches and error logic SHALL live in data_mem_responder.

Verification
REQ-035 Write-then-read, WAIT_CYCLES=2: write 0xDEADBEEF to 0x10, then read 0x10 -> read_data=0xDEADBEEF with mem_ready in cycle 3 of the read; mem_err=0.
REQ-036 WAIT_CYCLES=0: read request in cycle 0 -> mem_ready in cycle 1; back-to-back requests accepted every 2 cycles.
REQ-037 Misaligned write to 0x13 with data 0x1 -> mem_err=1 with mem_ready; a later read of 0x10 still returns the prior value.
REQ-038 Read of 0x400 with DEPTH=256 -> mem_err=1 and read_data=0; both enables high -> mem_err=1 and no memory change.
REQ-039 Write 0x12345678 to 0x20, reset pulsed during WAIT -> no mem_ready, mem_busy=0 the next cycle, and a later read of 0x20 returns the old value.
REQ-040 Change DataAddress during WAIT -> the response uses the latched address; mem_busy is high for exactly WAIT_CYCLES+1 cycles per request.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// ----------------------------------------------------------------------------
// data_mem_responder_pkg
// Shared definitions for the data memory responder: the FSM state encoding,
// the default geometry/latency constants and the latched-request record.
// ----------------------------------------------------------------------------
package data_mem_responder_pkg;

  // Fixed 2-bit encoding so the state value is stable for anyone probing it.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEFAULT_DEPTH       = 256;
  localparam int DEFAULT_WAIT_CYCLES = 2;
  localparam int COUNT_W             = 4;

  // Everything captured from the MEM stage at acceptance, except the word
  // index, whose width depends on DEPTH.
  typedef struct packed {
    logic        rd;
    logic        wr;
    logic        err;
    logic [31:0] data;
  } req_t;

endpackage

// File: rtl/data_mem_responder_word_array.sv
// ----------------------------------------------------------------------------
// dmem_word_array
// Single-port array of DEPTH 32-bit words with a synchronous write and a
// combinational read on the same address. Contents are never reset.
//
// Ports:
//   clk   - clock, writes occur on its rising edge
//   we    - write enable
//   addr  - word index (ADDR_W bits)
//   wdata - word to write
//   rdata - word currently stored at addr
// ----------------------------------------------------------------------------
module dmem_word_array #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
// Wait-state data memory for a pipeline MEM stage. A request seen in IDLE is
// latched, held for WAIT_CYCLES wait states, then answered with a one-cycle
// mem_ready strobe (plus mem_err for misaligned, out-of-range or read+write
// requests). Writes land at the edge that ends the response cycle.
//
// Ports:
//   clk         - clock
//   reset       - synchronous active-high reset (memory contents preserved)
//   read_En     - read request
//   write_En    - write request
//   DataAddress - byte address of the request
//   WriteData   - data for a write
//   read_data   - read result, valid only with mem_ready, 0 otherwise
//   mem_ready   - one-cycle response strobe
//   mem_err     - error flag, qualified by mem_ready
//   mem_busy    - high whenever a transaction is in progress (pipeline stall)
// ----------------------------------------------------------------------------
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read_En,
  input  logic        write_En,
  input  logic [31:0] DataAddress,
  input  logic [31:0] WriteData,
  output logic [31:0] read_data,
  output logic        mem_ready,
  output logic        mem_err,
  output logic        mem_busy
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // The counter holds the number of further WAIT cycles after the current one.
  localparam logic [COUNT_W-1:0] WAIT_LOAD =
    COUNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  state_t             state;
  state_t             state_next;
  logic [COUNT_W-1:0] count;
  req_t               req_q;
  logic [ADDR_W-1:0]  idx_q;

  logic               accept;
  logic               misaligned;
  logic               out_of_range;
  logic               req_err;

  logic               array_we;
  logic [31:0]        array_rdata;

  // The full 30-bit word index is compared, so high address bits make a
  // request out of range instead of aliasing onto a low word.
  assign accept       = (state == IDLE) && (read_En || write_En);
  assign misaligned   = (DataAddress[1:0] != 2'b00);
  assign out_of_range = ({2'b00, DataAddress[31:2]} >= 32'(DEPTH));
  assign req_err      = misaligned || out_of_range || (read_En && write_En);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Wait-state counter, loaded when a request heads into WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (accept && (WAIT_CYCLES > 0)) begin
      count <= WAIT_LOAD;
    end else if ((state == WAIT) && (count != '0)) begin
      count <= count - {{(COUNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Request capture. Inputs are only looked at on acceptance, so the
  // initiator may change them freely while a transaction is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q <= '0;
      idx_q <= '0;
    end else if (accept) begin
      req_q.rd   <= read_En;
      req_q.wr   <= write_En;
      req_q.err  <= req_err;
      req_q.data <= WriteData;
      idx_q      <= DataAddress[ADDR_W+1:2];
    end
  end

  // Next-state and response outputs.
  always_comb begin
    state_next = state;
    mem_ready  = 1'b0;
    mem_err    = 1'b0;
    mem_busy   = 1'b1;
    read_data  = '0;
    array_we   = 1'b0;

    case (state)
      IDLE: begin
        mem_busy = 1'b0;
        if (accept) begin
          state_next = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (count == '0) begin
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
        mem_ready  = 1'b1;
        mem_err    = req_q.err;
        if (req_q.rd && !req_q.err) begin
          read_data = array_rdata;
        end
        // A reset landing on this edge aborts the transaction, write included.
        array_we = req_q.wr && !req_q.err && !reset;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  dmem_word_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (array_we),
    .addr  (idx_q),
    .wdata (req_q.data),
    .rdata (array_rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_data_mem_responder
// Drives two responders (WAIT_CYCLES=2 and WAIT_CYCLES=0) with directed and
// random requests and compares every response against a word-array model.
// ----------------------------------------------------------------------------
module tb_data_mem_responder;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_en [2];
  logic        wr_en [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        ready [2];
  logic        err   [2];
  logic        busy  [2];

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] model_mem   [2][DEPTH];
  bit          model_known [2][DEPTH];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dut_w2 (
    .clk(clk), .reset(reset),
    .read_En(rd_en[0]), .write_En(wr_en[0]),
    .DataAddress(addr[0]), .WriteData(wdata[0]),
    .read_data(rdata[0]), .mem_ready(ready[0]),
    .mem_err(err[0]), .mem_busy(busy[0])
  );

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .reset(reset),
    .read_En(rd_en[1]), .write_En(wr_en[1]),
    .DataAddress(addr[1]), .WriteData(wdata[1]),
    .read_data(rdata[1]), .mem_ready(ready[1]),
    .mem_err(err[1]), .mem_busy(busy[1])
  );

  function automatic int wait_of(input int inst);
    return (inst == 0) ? 2 : 0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One complete transaction on instance inst. Called with the DUT idle; the
  // request is accepted at the next rising edge. abort_at>0 pulses reset
  // after the wait cycle with that number has been checked.
  task automatic applyStimulus(input int inst, input bit rd, input bit wr,
                               input logic [31:0] a, input logic [31:0] d,
                               input bit scramble, input int abort_at);
    int          w;
    int          idx;
    bit          exp_err;
    bit          check_data;
    logic [31:0] exp_rd;
    string       pfx;

    w       = wait_of(inst);
    idx     = int'(a / 4);
    exp_err = (a % 4 != 0) || (idx >= DEPTH) || (rd && wr);
    pfx     = $sformatf("w%0d a=%08h", w, a);

    exp_rd     = 32'h0;
    check_data = 1'b1;
    if (!exp_err && rd) begin
      if (model_known[inst][idx]) exp_rd = model_mem[inst][idx];
      else check_data = 1'b0;
    end

    rd_en[inst] = rd;
    wr_en[inst] = wr;
    addr[inst]  = a;
    wdata[inst] = d;
    @(posedge clk); #1;

    for (int k = 1; k <= w + 1; k++) begin
      checkOutput($sformatf("%s busy c%0d", pfx, k), 32'(busy[inst]), 32'd1);
      checkOutput($sformatf("%s ready c%0d", pfx, k), 32'(ready[inst]),
                  32'(k == w + 1));
      if (k == w + 1) begin
        checkOutput($sformatf("%s err", pfx), 32'(err[inst]), 32'(exp_err));
        if (check_data)
          checkOutput($sformatf("%s rdata", pfx), rdata[inst], exp_rd);
      end else begin
        checkOutput($sformatf("%s rdata idle c%0d", pfx, k), rdata[inst], 32'h0);
      end

      if (k == abort_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset       = 1'b0;
        rd_en[inst] = 1'b0;
        wr_en[inst] = 1'b0;
        checkOutput($sformatf("%s abort busy", pfx), 32'(busy[inst]), 32'd0);
        checkOutput($sformatf("%s abort ready", pfx), 32'(ready[inst]), 32'd0);
        checkOutput($sformatf("%s abort rdata", pfx), rdata[inst], 32'h0);
        return;
      end

      if (k < w + 1) begin
        if (scramble) begin
          addr[inst]  = $urandom;
          wdata[inst] = $urandom;
        end
        @(posedge clk); #1;
      end
    end

    rd_en[inst] = 1'b0;
    wr_en[inst] = 1'b0;
    if (wr && !exp_err) begin
      model_mem[inst][idx]   = d;
      model_known[inst][idx] = 1'b1;
    end
    @(posedge clk); #1;
    checkOutput($sformatf("%s back idle busy", pfx), 32'(busy[inst]), 32'd0);
    checkOutput($sformatf("%s back idle ready", pfx), 32'(ready[inst]), 32'd0);
  endtask

  initial begin
    int          sel;
    int          op;
    bit          rd;
    bit          wr;
    int          abort_at;
    logic [31:0] a;

    for (int i = 0; i < 2; i++) begin
      rd_en[i] = 1'b0;
      wr_en[i] = 1'b0;
      addr[i]  = 32'h0;
      wdata[i] = 32'h0;
      for (int j = 0; j < DEPTH; j++) model_known[i][j] = 1'b0;
    end

    // Reset with a request pending: the request must be ignored.
    reset    = 1'b1;
    rd_en[0] = 1'b1;
    wr_en[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rd_en[0] = 1'b0;
    wr_en[1] = 1'b0;
    reset    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("reset busy %0d", i), 32'(busy[i]), 32'd0);
      checkOutput($sformatf("reset ready %0d", i), 32'(ready[i]), 32'd0);
      checkOutput($sformatf("reset err %0d", i), 32'(err[i]), 32'd0);
      checkOutput($sformatf("reset rdata %0d", i), rdata[i], 32'h0);
    end

    // Give every word a known value.
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < DEPTH; j++)
        applyStimulus(i, 1'b0, 1'b1, 32'(j * 4), $urandom, 1'b0, -1);

    // Write-then-read at 0x10.
    applyStimulus(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, -1);
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, -1);
    checkOutput("model 0x10", model_mem[0][4], 32'hDEADBEEF);

    // Misaligned write must not disturb 0x10.
    applyStimulus(0, 1'b0, 1'b1, 32'h13, 32'h1, 1'b0, -1);
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, -1);

    // Out of range, high-bit aliasing, and both enables.
    applyStimulus(0, 1'b1, 1'b0, 32'h400, 32'h0, 1'b0, -1);
    applyStimulus(0, 1'b1, 1'b0, 32'h8000_0010, 32'h0, 1'b0, -1);
    applyStimulus(0, 1'b0, 1'b1, 32'h8000_0010, 32'h5555_AAAA, 1'b0, -1);
    applyStimulus(0, 1'b1, 1'b1, 32'h10, 32'h0, 1'b0, -1);
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, -1);

    // Write aborted by reset during WAIT, then read of the old value.
    applyStimulus(0, 1'b0, 1'b1, 32'h20, 32'h12345678, 1'b0, 1);
    applyStimulus(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, -1);

    // Inputs changed during WAIT are ignored.
    applyStimulus(0, 1'b0, 1'b1, 32'h30, 32'hCAFEF00D, 1'b1, -1);
    applyStimulus(0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b1, -1);

    // Zero wait states, back-to-back requests.
    applyStimulus(1, 1'b0, 1'b1, 32'h40, 32'hA5A5_0001, 1'b0, -1);
    applyStimulus(1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, -1);
    applyStimulus(1, 1'b1, 1'b0, 32'h3FC, 32'h0, 1'b0, -1);
    applyStimulus(1, 1'b1, 1'b0, 32'h400, 32'h0, 1'b0, -1);

    // Random traffic on both instances.
    for (int n = 0; n < 400; n++) begin
      sel = n % 2;
      case ($urandom_range(0, 9))
        0:       a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
        1:       a = 32'($urandom_range(DEPTH, 32'h3FFF_FFFF)) << 2;
        default: a = 32'($urandom_range(0, DEPTH - 1) * 4);
      endcase
      op = $urandom_range(0, 19);
      rd = (op < 10);
      wr = (op >= 9);
      abort_at = -1;
      if (wait_of(sel) > 0 && $urandom_range(0, 19) == 0)
        abort_at = $urandom_range(1, wait_of(sel));
      applyStimulus(sel, rd, wr, a, $urandom, 1'($urandom_range(0, 1)), abort_at);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
